// File: rtl/mem_port_sched.sv
// mem_port_sched: single-port memory scheduler shared by instruction fetch (IF)
// and data access (EX) of the 16-bit 3-stage pipeline.
//
// One access is granted at a time. The access holds the memory port for MEM_LAT
// cycles (WAIT) and then pulses the owner's valid for one cycle (RESP). At least
// one IDLE cycle separates accesses. All state updates on the falling clock edge,
// matching the pipeline registers.
//
// Ports:
//   clock, reset          falling-edge clock, asynchronous active-high reset
//   if_req/if_addr        fetch request (level, held until if_valid) and byte address
//   ex_req/ex_we/ex_addr/ex_wdata
//                         data request (level, held until ex_valid), store flag,
//                         byte address and store data
//   mem_rdata             read data from the memory array
//   mem_en/mem_we/mem_addr/mem_wdata
//                         memory port; mem_addr is a word address (byte addr >> 1)
//   if_valid/if_rdata     fetch completion pulse and fetched instruction
//   ex_valid/ex_rdata     load/store completion pulse and load data
//   stall                 freeze PC/IFID/IDEX while any request is unserved
module mem_port_sched #(
  parameter int MEM_LAT = 2,
  parameter int MAX_RUN = 3,
  parameter int ADDR_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [15:0]       ex_addr,
  input  logic [15:0]       ex_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              if_valid,
  output logic [15:0]       if_rdata,
  output logic              ex_valid,
  output logic [15:0]       ex_rdata,
  output logic              stall
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);
  localparam logic [2:0] RUN_LIM  = 3'(MAX_RUN);
  localparam logic [2:0] RUN_SAT  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_ex_q, owner_ex_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          run_q, run_d;
  logic [15:0]         if_rdata_q, if_rdata_d;
  logic [15:0]         ex_rdata_q, ex_rdata_d;
  logic                grant_ex;

  // Byte-lane bit 0 and the bits above the array size are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[15:ADDR_W+1], if_addr[0],
                              ex_addr[15:ADDR_W+1], ex_addr[0]};

  // Consecutive-EX-grant counter saturates rather than wrapping, so a long EX
  // burst can never make IF look un-starved again.
  function automatic logic [2:0] run_sat_inc(input logic [2:0] v);
    return (v == RUN_SAT) ? v : v + 3'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    owner_ex_d = owner_ex_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    if_rdata_d = if_rdata_q;
    ex_rdata_d = ex_rdata_q;
    grant_ex   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || ex_req) begin
          // EX normally wins; IF is forced once EX has taken MAX_RUN grants
          // in a row while a fetch was waiting.
          grant_ex   = ex_req && ((run_q < RUN_LIM) || !if_req);
          owner_ex_d = grant_ex;
          if (grant_ex) begin
            addr_d  = ex_addr[ADDR_W:1];
            we_d    = ex_we;
            wdata_d = ex_wdata;
            run_d   = if_req ? run_sat_inc(run_q) : 3'd0;
          end else begin
            addr_d  = if_addr[ADDR_W:1];
            we_d    = 1'b0;
            run_d   = 3'd0;
          end
          cnt_d   = LAT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          // Stores leave ex_rdata untouched.
          if (owner_ex_q) begin
            if (!we_q) begin
              ex_rdata_d = mem_rdata;
            end
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_ex_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 3'd0;
      run_q      <= 3'd0;
      if_rdata_q <= '0;
      ex_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_ex_q <= owner_ex_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      if_rdata_q <= if_rdata_d;
      ex_rdata_q <= ex_rdata_d;
    end
  end

  // Port controls decode straight from state so reset drops them immediately.
  assign mem_en    = (state_q == S_WAIT);
  assign mem_we    = (state_q == S_WAIT) && owner_ex_q && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_valid  = (state_q == S_RESP) && !owner_ex_q;
  assign ex_valid  = (state_q == S_RESP) && owner_ex_q;
  assign if_rdata  = if_rdata_q;
  assign ex_rdata  = ex_rdata_q;
  assign stall     = (if_req && !if_valid) || (ex_req && !ex_valid);

endmodule

// File: tb/tb_mem_port_sched.sv
module tb_mem_port_sched;

  localparam int LAT  = 2;
  localparam int MAXR = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        ex_req = 1'b0;
  logic        ex_we = 1'b0;
  logic [15:0] ex_addr = '0;
  logic [15:0] ex_wdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_en, mem_we, if_valid, ex_valid, stall;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata, if_rdata, ex_rdata;

  // second instance: single-cycle memory latency
  logic        r1_if_req = 1'b0;
  logic [15:0] r1_if_addr = '0;
  logic [15:0] r1_mem_rdata;
  logic        r1_mem_en, r1_mem_we, r1_if_valid, r1_ex_valid, r1_stall;
  logic [9:0]  r1_mem_addr;
  logic [15:0] r1_mem_wdata, r1_if_rdata, r1_ex_rdata;

  always #5 clock = ~clock;

  mem_port_sched #(.MEM_LAT(LAT), .MAX_RUN(MAXR), .ADDR_W(10)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ex_valid(ex_valid), .ex_rdata(ex_rdata),
    .stall(stall)
  );

  mem_port_sched #(.MEM_LAT(1), .MAX_RUN(1), .ADDR_W(10)) u_lat1 (
    .clock(clock), .reset(reset),
    .if_req(r1_if_req), .if_addr(r1_if_addr),
    .ex_req(1'b0), .ex_we(1'b0), .ex_addr(16'h0000), .ex_wdata(16'h0000),
    .mem_rdata(r1_mem_rdata),
    .mem_en(r1_mem_en), .mem_we(r1_mem_we), .mem_addr(r1_mem_addr), .mem_wdata(r1_mem_wdata),
    .if_valid(r1_if_valid), .if_rdata(r1_if_rdata),
    .ex_valid(r1_ex_valid), .ex_rdata(r1_ex_rdata),
    .stall(r1_stall)
  );

  function automatic logic [15:0] mem_fn(input logic [9:0] a);
    return {a[5:0], a} ^ 16'h5A3C;
  endfunction

  // Memory array model: data appears only in the LAT-th cycle of an enable run.
  int en_age;
  always @(negedge clock or posedge reset) begin
    if (reset) en_age <= 0;
    else       en_age <= mem_en ? en_age + 1 : 0;
  end
  assign mem_rdata    = (mem_en && en_age == LAT - 1) ? mem_fn(mem_addr) : 16'hBAD0;
  assign r1_mem_rdata = r1_mem_en ? mem_fn(r1_mem_addr) : 16'hBAD1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: age counts cycles since the grant edge.
  // 1..LAT: port busy; LAT+1: owner's valid; >= LAT+2 (or <0): free to grant.
  int          m_age = -1;
  int          m_run = 0;
  bit          m_own_ex = 0;
  bit          m_we = 0;
  logic [9:0]  m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_if_rdata = '0;
  logic [15:0] m_ex_rdata = '0;
  bit          exp_ifv = 0;
  bit          exp_exv = 0;

  task automatic model_reset();
    m_age = -1; m_run = 0; m_if_rdata = '0; m_ex_rdata = '0;
    exp_ifv = 0; exp_exv = 0;
  endtask

  task automatic tick();
    bit exp_en;
    @(posedge clock);
    if (m_age >= 0) m_age++;
    exp_en  = (m_age >= 1) && (m_age <= LAT);
    exp_ifv = (m_age == LAT + 1) && !m_own_ex;
    exp_exv = (m_age == LAT + 1) && m_own_ex;
    if (exp_ifv) m_if_rdata = mem_fn(m_addr);
    if (exp_exv && !m_we) m_ex_rdata = mem_fn(m_addr);
    chk("mem_en", mem_en, exp_en);
    chk("mem_we", mem_we, exp_en && m_own_ex && m_we);
    if (exp_en) chk("mem_addr", mem_addr, m_addr);
    if (exp_en && m_own_ex && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_valid", if_valid, exp_ifv);
    chk("ex_valid", ex_valid, exp_exv);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("ex_rdata", ex_rdata, m_ex_rdata);
    if (exp_ifv) if_req = 1'b0;
    if (exp_exv) ex_req = 1'b0;
  endtask

  // Called after this cycle's inputs are driven; models the coming falling edge.
  task automatic decide();
    bit win;
    #1;
    chk("stall", stall, (if_req && !exp_ifv) || (ex_req && !exp_exv));
    if ((m_age < 0 || m_age >= LAT + 2) && (if_req || ex_req)) begin
      win = ex_req && (m_run < MAXR || !if_req);
      if (win) m_run = if_req ? ((m_run < 7) ? m_run + 1 : 7) : 0;
      else     m_run = 0;
      m_own_ex = win;
      m_addr   = win ? ex_addr[10:1] : if_addr[10:1];
      m_we     = win && ex_we;
      m_wdata  = ex_wdata;
      m_age    = 0;
    end
  endtask

  typedef struct {
    bit          if_req;
    logic [15:0] if_addr;
    bit          ex_req;
    bit          ex_we;
    logic [15:0] ex_addr;
    logic [15:0] ex_wdata;
    bit          exp_first_ex;
    logic [9:0]  exp_addr1;
    bit          exp_we1;
    logic [15:0] exp_wdata1;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    bit seen_en = 0;
    bit seen_v = 0;
    int guard = 0;
    tick();
    if_req = v.if_req; if_addr = v.if_addr;
    ex_req = v.ex_req; ex_we = v.ex_we; ex_addr = v.ex_addr; ex_wdata = v.ex_wdata;
    decide();
    while ((if_req || ex_req) && guard < 40) begin
      tick();
      guard++;
      if (!seen_en && mem_en) begin
        seen_en = 1;
        chk($sformatf("v%0d_addr", idx), mem_addr, v.exp_addr1);
        chk($sformatf("v%0d_we", idx), mem_we, v.exp_we1);
        if (v.exp_we1) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.exp_wdata1);
      end
      if (!seen_v && (if_valid || ex_valid)) begin
        seen_v = 1;
        chk($sformatf("v%0d_first_owner", idx), ex_valid, v.exp_first_ex);
      end
      decide();
    end
    chk($sformatf("v%0d_done", idx), (guard < 40) && seen_v, 1);
    repeat (2) begin tick(); decide(); end
  endtask

  vec_t vecs[7];
  int   got[8];
  int   pat[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard;
    vecs[0] = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h002, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 16'h0020, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 10'h008, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 16'h00AB, 1'b1, 10'h003, 1'b1, 16'h00AB};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 10'h3FF, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 16'h0100, 1'b1, 1'b1, 16'h0202, 16'h1234, 1'b1, 10'h101, 1'b1, 16'h1234};
    vecs[5] = '{1'b1, 16'h07FE, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h3FF, 1'b0, 16'h0000};
    vecs[6] = '{1'b1, 16'hF802, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h001, 1'b0, 16'h0000};
    pat = '{1, 1, 1, 0, 1, 1, 1, 0};

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_valids", {if_valid, ex_valid}, 0);
    chk("rst_rdata", {if_rdata, ex_rdata}, 0);
    chk("rst_stall", stall, 0);
    @(posedge clock);
    #2 reset = 1'b0;
    model_reset();

    // directed vectors
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // starvation guard: both requesters keep requesting
    tick();
    if_req = 1'b1; if_addr = 16'h0300;
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 16'h0040;
    decide();
    n = 0; guard = 0;
    while (n < 8 && guard < 200) begin
      tick();
      guard++;
      if (if_valid || ex_valid) begin got[n] = ex_valid ? 1 : 0; n++; end
      if (!if_req) begin if_req = 1'b1; if_addr = 16'($urandom); end
      if (!ex_req) begin
        ex_req = 1'b1; ex_we = 1'($urandom_range(0, 1));
        ex_addr = 16'($urandom); ex_wdata = 16'($urandom);
      end
      decide();
    end
    chk("starve_done", n, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("starve_order%0d", i), got[i], pat[i]);
    if_req = 1'b0; ex_req = 1'b0;
    repeat (LAT + 4) begin tick(); decide(); end

    // reset in the middle of a fetch
    tick();
    if_req = 1'b1; if_addr = 16'h0044;
    decide();
    tick();
    decide();
    #1 reset = 1'b1;
    #1;
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_if_valid", if_valid, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    model_reset();
    @(posedge clock);
    chk("midrst_no_pulse", if_valid, 0);
    #2 reset = 1'b0;
    decide();
    guard = 0;
    while (if_req && guard < 20) begin tick(); guard++; decide(); end
    chk("midrst_restart_done", guard < 20, 1);
    chk("midrst_restart_data", if_rdata, mem_fn(10'h022));
    repeat (2) begin tick(); decide(); end

    // single-cycle latency instance
    tick();
    r1_if_req = 1'b1; r1_if_addr = 16'h0008;
    decide();
    chk("lat1_stall", r1_stall, 1);
    tick();
    chk("lat1_en", r1_mem_en, 1);
    chk("lat1_addr", r1_mem_addr, 10'h004);
    chk("lat1_early_valid", r1_if_valid, 0);
    decide();
    tick();
    chk("lat1_valid", r1_if_valid, 1);
    chk("lat1_rdata", r1_if_rdata, mem_fn(10'h004));
    chk("lat1_en_off", r1_mem_en, 0);
    r1_if_req = 1'b0;
    decide();
    tick();
    chk("lat1_valid_off", r1_if_valid, 0);
    decide();

    // randomized traffic against the reference
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = 16'($urandom);
      end
      if (!ex_req && $urandom_range(0, 3) == 0) begin
        ex_req = 1'b1; ex_we = 1'($urandom_range(0, 1));
        ex_addr = 16'($urandom); ex_wdata = 16'($urandom);
      end
      decide();
    end
    guard = 0;
    while ((if_req || ex_req) && guard < 40) begin tick(); guard++; decide(); end
    chk("rand_drain", guard < 40, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
